// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame length and default timing.
// Used by both the host transmitter and the PS/2 receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIB,
        REQ,
        BITS,
        ACK,
        WREL
    } ps2_state_e;

    // Last bit index of a host frame: 8 data bits, parity, stop.
    localparam int BITS_LAST       = 9;
    localparam int INHIBIT_DEFAULT = 2800;
    localparam int TIMEOUT_DEFAULT = 420000;
    localparam int FILTER_LEN      = 8;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// PS/2 pad synchronizer with clock edge strobes.
// Define PS2TX_FILTER_EN to add an 8-sample stability filter on the clock line.
module ps2_sync
    import ps2_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic ck_i,
    input  logic d_i,
    output logic ck_s,
    output logic d_s,
    output logic ck_fall,
    output logic ck_rise
);

    logic ck_meta_q, ck_sync_q;
    logic d_meta_q, d_sync_q;
    logic ck_prev_q;
    logic ck_clean;

    // Idle bus is high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_meta_q <= 1'b1;
            ck_sync_q <= 1'b1;
            d_meta_q  <= 1'b1;
            d_sync_q  <= 1'b1;
        end else begin
            ck_meta_q <= ck_i;
            ck_sync_q <= ck_meta_q;
            d_meta_q  <= d_i;
            d_sync_q  <= d_meta_q;
        end
    end

`ifdef PS2TX_FILTER_EN
    logic       ck_filt_q, ck_filt_d;
    logic [2:0] filt_cnt_q, filt_cnt_d;

    // Follow the synced clock only after FILTER_LEN consecutive differing samples.
    always_comb begin
        ck_filt_d  = ck_filt_q;
        filt_cnt_d = '0;
        if (ck_sync_q != ck_filt_q) begin
            if (filt_cnt_q == 3'(FILTER_LEN - 1)) begin
                ck_filt_d = ck_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_filt_q  <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            ck_filt_q  <= ck_filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign ck_clean = ck_filt_q;
`else
    assign ck_clean = ck_sync_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_prev_q <= 1'b1;
        end else begin
            ck_prev_q <= ck_clean;
        end
    end

    assign ck_s    = ck_clean;
    assign d_s     = d_sync_q;
    assign ck_fall = ck_prev_q & ~ck_clean;
    assign ck_rise = ~ck_prev_q & ck_clean;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 10 bits, ACK check.
// Optional PS2TX_FILTER_EN enables the clock stability filter in ps2_sync.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT = INHIBIT_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       strb,
    input  logic [7:0] data,
    input  logic       ps2CkI,
    input  logic       ps2DI,
    output logic       ps2CkOe,
    output logic       ps2DOe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int TMAX = (TIMEOUT > INHIBIT) ? TIMEOUT : INHIBIT;
    localparam int TW   = $clog2(TMAX + 1);

    logic ck_s, d_s, ck_fall;
    logic unused_ck_rise;

    ps2_sync u_sync (
        .clock   (clock),
        .reset   (reset),
        .ck_i    (ps2CkI),
        .d_i     (ps2DI),
        .ck_s    (ck_s),
        .d_s     (d_s),
        .ck_fall (ck_fall),
        .ck_rise (unused_ck_rise)
    );

    ps2_state_e    state_q, state_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ck_oe_q, ck_oe_d;
    logic          d_oe_q, d_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          timed;
    logic          abort;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ck_oe_d   = ck_oe_q;
        d_oe_d    = d_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        abort     = 1'b0;
        timed     = (state_q == BITS) || (state_q == ACK) || (state_q == WREL);
        timer_d   = (timed && ck_fall) ? '0 : timer_q + TW'(1);

        case (state_q)
            IDLE: begin
                timer_d = '0;
                // A request landing on a done/error cycle is dropped, not queued.
                if (strb && !done_q && !error_q) begin
                    shift_d = {odd_parity(data), data};
                    busy_d  = 1'b1;
                    ck_oe_d = 1'b1;
                    state_d = INHIB;
                end
            end
            INHIB: begin
                // Start bit goes low one cycle before the clock is released,
                // so REQ completes exactly INHIBIT cycles of clock hold.
                if (timer_q == TW'(INHIBIT - 2)) begin
                    d_oe_d  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                ck_oe_d   = 1'b0;
                bit_cnt_d = '0;
                state_d   = BITS;
            end
            BITS: begin
                if (ck_fall) begin
                    if (bit_cnt_q == 4'(BITS_LAST)) begin
                        d_oe_d  = 1'b0;
                        state_d = ACK;
                    end else begin
                        d_oe_d    = ~shift_q[0];
                        shift_d   = {1'b1, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ACK: begin
                if (ck_fall) begin
                    if (!d_s) begin
                        state_d = WREL;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            WREL: begin
                if (ck_s && d_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timed && !ck_fall && (state_d == state_q) && (timer_q == TW'(TIMEOUT - 1))) begin
            abort = 1'b1;
        end

        if (abort) begin
            state_d = IDLE;
            ck_oe_d = 1'b0;
            d_oe_d  = 1'b0;
            busy_d  = 1'b0;
            error_d = 1'b1;
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            ck_oe_q   <= 1'b0;
            d_oe_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            ck_oe_q   <= ck_oe_d;
            d_oe_q    <= d_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign ps2CkOe = ck_oe_q;
    assign ps2DOe  = d_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule
